// File: rtl/rr_arbiter_n.sv
// -----------------------------------------------------------------------------
// rr_arbiter_n : N-way round-robin arbiter with a registered one-hot grant.
//
// Purpose
//   Grants a shared resource to at most one of N requesters per cycle. Priority
//   rotates after every grant: the search starts one past the most recent
//   winner ("last") and wraps modulo N. This gives every continuously
//   requesting requester a grant within N cycles.
//
// Ports
//   clk          in   1    rising-edge clock
//   reset        in   1    synchronous, active-high reset
//   request      in   N    request[i]=1 : requester i wants the resource
//   lock         in   N    lock[i]=1    : owner i asks to keep the grant
//   grant        out  N    registered one-hot (or zero) grant
//   grant_valid  out  1    registered, equals |grant
//   grant_id     out  IDW  registered index of the granted requester, 0 if idle
//
// Configuration
//   ARB_LOCK_EN  when defined, an owner holding both request and lock keeps
//                the grant and the rotation pointer is frozen. When undefined,
//                the lock input is accepted but has no effect.
// -----------------------------------------------------------------------------

// Per-requester slot: flags whether this lane lies strictly after the last
// winner in index order, i.e. belongs to the "upper" half of the rotation.
module rr_arb_lane #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2,
  parameter int unsigned IDX = 0
) (
  input  logic [IDW-1:0] last_i,
  input  logic           req_i,
  output logic           upper_o
);
  localparam logic [IDW-1:0] IDX_W = IDW'(IDX);

  assign upper_o = req_i && (IDX_W > last_i);
endmodule

module rr_arbiter_n #(
  parameter int unsigned N = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N-1:0]                    request,
  input  logic [N-1:0]                    lock,
  output logic [N-1:0]                    grant,
  output logic                            grant_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id
);
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;

  logic [N-1:0]   upper_req;
  logic [N-1:0]   pick;

  // Lowest set bit of a vector, as a one-hot (zero if the vector is zero).
  function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
    logic [N-1:0] r;
    logic         found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // One-hot to binary; returns 0 for a zero vector.
  function automatic logic [IDW-1:0] encode(input logic [N-1:0] oh);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) r = r | IDW'(i);
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      rr_arb_lane #(.N(N), .IDW(IDW), .IDX(gi)) u_lane (
        .last_i  (last_q),
        .req_i   (request[gi]),
        .upper_o (upper_req[gi])
      );
    end
  endgenerate

  // Rotation without modular arithmetic: requesters above last come first in
  // index order; if none, the search wraps to the lowest requester overall.
  // This holds for any N, power of two or not.
  assign pick = (|upper_req) ? lowest(upper_req) : lowest(request);

`ifdef ARB_LOCK_EN
  logic hold;
  // Only the current owner's lock bit can match grant_q, so lock[j] on a
  // non-owner has no effect.
  assign hold = |(grant_q & request & lock);
`else
  logic lock_unused;
  assign lock_unused = ^lock;
`endif

  always_comb begin
    grant_d = pick;
    last_d  = last_q;
    if (|pick) last_d = encode(pick);
`ifdef ARB_LOCK_EN
    if (hold) begin
      grant_d = grant_q;
      last_d  = last_q;
    end
`endif
    valid_d = |grant_d;
    id_d    = encode(grant_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      // Pointer at N-1 makes requester 0 highest priority after reset.
      last_q  <= IDW'(N - 1);
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
endmodule

// File: tb/tb_rr_arbiter_n.sv
module tb_rr_arbiter_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic       rst4;
  logic [3:0] req4, lk4, g4;
  logic       gv4;
  logic [1:0] gid4;

  rr_arbiter_n #(.N(4)) u4 (
    .clk(clk), .reset(rst4), .request(req4), .lock(lk4),
    .grant(g4), .grant_valid(gv4), .grant_id(gid4)
  );

  // N=3 instance (non-power-of-two wrap)
  logic       rst3;
  logic [2:0] req3, lk3, g3;
  logic       gv3;
  logic [1:0] gid3;

  rr_arbiter_n #(.N(3)) u3 (
    .clk(clk), .reset(rst3), .request(req3), .lock(lk3),
    .grant(g3), .grant_valid(gv3), .grant_id(gid3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lk;
    logic [3:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] l,
                     input logic [3:0] ex, input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.lk = l; v.exp = ex; v.name = nm;
    vecs.push_back(v);
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check4();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    cmp({e.name, ".grant"},       32'(g4),   32'(e.g));
    cmp({e.name, ".grant_valid"}, 32'(gv4),  32'(|e.g));
    cmp({e.name, ".grant_id"},    32'(gid4), 32'(enc(e.g)));
  endtask

  // Expected sequence for N=3: reset, 111 x4, 101 x3, 000
  logic       r3_seq [9];
  logic [2:0] q3_seq [9];
  logic [2:0] e3_seq [9];

  initial begin
    exp_t e;
    rst4 = 1'b1; req4 = '0; lk4 = '0;
    rst3 = 1'b1; req3 = '0; lk3 = '0;

    // Full rotation after reset
    add(1, 4'b1111, 4'b0000, 4'b0000, "rst");
    add(0, 4'b1111, 4'b0000, 4'b0001, "all0");
    add(0, 4'b1111, 4'b0000, 4'b0010, "all1");
    add(0, 4'b1111, 4'b0000, 4'b0100, "all2");
    add(0, 4'b1111, 4'b0000, 4'b1000, "all3");
    add(0, 4'b1111, 4'b0000, 4'b0001, "all4");
    add(0, 4'b1111, 4'b0000, 4'b0010, "all5");
    add(0, 4'b1111, 4'b0000, 4'b0100, "all6");
    add(0, 4'b1111, 4'b0000, 4'b1000, "all7");
    // Sparse pattern alternates, 0 and 2 never win
    add(1, 4'b1010, 4'b0000, 4'b0000, "rst2");
    add(0, 4'b1010, 4'b0000, 4'b0010, "alt0");
    add(0, 4'b1010, 4'b0000, 4'b1000, "alt1");
    add(0, 4'b1010, 4'b0000, 4'b0010, "alt2");
    add(0, 4'b1010, 4'b0000, 4'b1000, "alt3");
    // Lone requester, idle, then wrap from last=2 to index 0
    add(0, 4'b0100, 4'b0000, 4'b0100, "solo0");
    add(0, 4'b0100, 4'b0000, 4'b0100, "solo1");
    add(0, 4'b0100, 4'b0000, 4'b0100, "solo2");
    add(0, 4'b0000, 4'b0000, 4'b0000, "idle");
    add(0, 4'b0101, 4'b0000, 4'b0001, "wrap");
    // Mid-stream reset drops grant at once
    add(1, 4'b1111, 4'b0000, 4'b0000, "rst3");
    add(0, 4'b1111, 4'b0000, 4'b0001, "mid0");
    add(0, 4'b1111, 4'b0000, 4'b0010, "mid1");
    add(1, 4'b1111, 4'b0000, 4'b0000, "midrst");
    add(0, 4'b1111, 4'b0000, 4'b0001, "midrel");
    // Lock sequence
    add(1, 4'b1111, 4'b0001, 4'b0000, "rst4");
    add(0, 4'b1111, 4'b0001, 4'b0001, "lk0");
`ifdef ARB_LOCK_EN
    add(0, 4'b1111, 4'b0001, 4'b0001, "lk1");
    add(0, 4'b1111, 4'b0001, 4'b0001, "lk2");
    add(0, 4'b1111, 4'b0001, 4'b0001, "lk3");
    add(0, 4'b1111, 4'b0001, 4'b0001, "lk4");
`else
    add(0, 4'b1111, 4'b0001, 4'b0010, "lk1");
    add(0, 4'b1111, 4'b0001, 4'b0100, "lk2");
    add(0, 4'b1111, 4'b0001, 4'b1000, "lk3");
    add(0, 4'b1111, 4'b0001, 4'b0001, "lk4");
`endif
    add(0, 4'b1111, 4'b0000, 4'b0010, "unlk");
    add(0, 4'b1111, 4'b0100, 4'b0100, "nonowner");
`ifdef ARB_LOCK_EN
    add(0, 4'b1111, 4'b0100, 4'b0100, "lk2hold");
`else
    add(0, 4'b1111, 4'b0100, 4'b1000, "lk2hold");
`endif
    add(1, 4'b1111, 4'b1111, 4'b0000, "rstlock");
    add(0, 4'b1111, 4'b0000, 4'b0001, "postrst");
    add(0, 4'b1110, 4'b0001, 4'b0010, "reqdrop");

    // Scoreboard: expectation pushed when driven, popped after the edge
    foreach (vecs[k]) begin
      @(negedge clk);
      check4();
      rst4 = vecs[k].rst; req4 = vecs[k].req; lk4 = vecs[k].lk;
      e.g = vecs[k].exp; e.name = vecs[k].name;
      sb.push_back(e);
    end
    @(negedge clk);
    check4();
    rst4 = 1'b0; req4 = '0;

    // N=3 hand-written wrap sequence
    r3_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    q3_seq = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
               3'b101, 3'b101, 3'b101, 3'b000};
    e3_seq = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001,
               3'b100, 3'b001, 3'b100, 3'b000};
    for (int k = 0; k < 9; k++) begin
      logic [1:0] eid;
      rst3 = r3_seq[k]; req3 = q3_seq[k]; lk3 = '0;
      @(negedge clk);
      eid = 2'd0;
      for (int i = 0; i < 3; i++) if (e3_seq[k][i]) eid = 2'(i);
      cmp($sformatf("n3[%0d].grant", k),       32'(g3),   32'(e3_seq[k]));
      cmp($sformatf("n3[%0d].grant_valid", k), 32'(gv3),  32'(|e3_seq[k]));
      cmp($sformatf("n3[%0d].grant_id", k),    32'(gid3), 32'(eid));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
